pico_l15_bridge: RTL and testbench
==================================

Name: pico_l15_bridge

Overview:
- Converts a PicoRV32-style 32-bit valid/ready memory interface into OpenPiton L1.5 request/response transactions.
- Sits between a core, or the rv_addr_line_en_initiator BFM, and the tile L1.5.
- Issues one outstanding request at a time and returns read data and interrupts to the core.

Parameters:
- PHY_ADDR_WIDTH, 40, width of the L1.5 physical address.
- AMO_OP_WIDTH, 4, width of the AMO opcode field.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pico_transducer_mem_valid  in  1  core request valid
- pico_transducer_mem_addr  in  32  byte address
- pico_transducer_mem_wstrb  in  4  byte write strobes; 0 means read
- pico_transducer_mem_wdata  in  32  write data, little-endian
- pico_transducer_mem_amo_op  in  AMO_OP_WIDTH  AMO opcode; 0 means none
- transducer_pico_mem_ready  out  1  one-cycle completion pulse
- transducer_pico_mem_rdata  out  32  read data, valid with ready
- pico_int  out  1  one-cycle interrupt pulse
- transducer_l15_val  out  1  request valid
- transducer_l15_rqtype  out  5  request type
- transducer_l15_amo_op  out  AMO_OP_WIDTH  AMO opcode
- transducer_l15_size  out  3  access size
- transducer_l15_address  out  PHY_ADDR_WIDTH  physical address
- transducer_l15_data  out  64  store data
- transducer_l15_nc  out  1  non-cacheable
- l15_transducer_ack  in  1  request accepted
- l15_transducer_header_ack  in  1  header accepted; informational only
- transducer_l15_threadid  out  1  tied to 0
- transducer_l15_prefetch, transducer_l15_invalidate_cacheline, transducer_l15_blockstore, transducer_l15_blockinitstore  out  1 each  tied to 0
- transducer_l15_l1rplway  out  2  tied to 0
- transducer_l15_data_next_entry  out  64  tied to 0
- transducer_l15_csm_data  out  33  tied to 0
- l15_transducer_val  in  1  response valid
- l15_transducer_returntype  in  4  response type
- l15_transducer_data_0  in  64  response data word 0
- l15_transducer_data_1  in  64  response data word 1; unused
- transducer_l15_req_ack  out  1  response consumed

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0.
  - Reset mid-transaction abandons it; no ready is produced.
- States: IDLE, REQ, WAIT.
- IDLE, when pico valid=1: latch all request fields; next cycle state=REQ with transducer_l15_val=1.
- Request type:
  - amo_op!=0: AMO 5'b00110, size 3'b010.
  - else wstrb!=0: STORE 5'b00001.
  - else: LOAD 5'b00000, size 3'b010.
- Store size from wstrb:
  - 4'hF gives 3'b010.
  - 4'h3 or 4'hC gives 3'b001.
  - A single bit gives 3'b000.
  - Any other pattern is issued as 3'b010.
- Address and nc:
  - address = zero-extended mem_addr.
  - nc = mem_addr[31].
- Data path (L1.5 is big-endian): transducer_l15_data = {bs(wdata), bs(wdata)}, where bs = byte swap.
- REQ: hold val and all fields stable until l15_transducer_ack=1, then state=WAIT and val=0 on the next cycle.
- WAIT, on l15_transducer_val:
  - transducer_l15_req_ack=1 combinationally in the same cycle.
  - Expected returntype: LOAD_RET 4'b0000 for load, ST_ACK 4'b0100 for store, AMO_RET 4'b1001 for AMO.
  - On expected returntype: next cycle mem_ready=1 for exactly one cycle with rdata valid, then state=IDLE.
  - rdata = bs(addr[2] ? data_0[31:0] : data_0[63:32]); store rdata = 0.
- Interrupt: returntype INT_RET 4'b0111 in any state gives req_ack=1 and pico_int=1 next cycle for one cycle; state unchanged.
- Any other unexpected response: req_ack=1, silently dropped.
- Request rule: IDLE samples pico valid on the cycle after ready. Masters must drop valid for at least one cycle after ready, otherwise the request is re-issued.
- Minimum latency: valid to l15 val is 1 cycle; l15 response to ready is 1 cycle.

Decomposition:
- Shared package l15_pkg holds:
  - rqtype constants LOAD/STORE/AMO.
  - returntype constants LOAD_RET/ST_ACK/AMO_RET/INT_RET.
  - size encodings.
  - PHY_ADDR_WIDTH and AMO_OP_WIDTH defaults.
  - a byte_swap32 function.
- No sub-module required.
- The companion rv_addr_line_en_initiator_bfm is a separate block used only by benches.

Test Plan:
- Load addr 0x0000_1004, l15 returns LOAD_RET, data_0=0x11223344_AABBCCDD -> rqtype 0, size 010, address 0x00_0000_1004, nc 0; req_ack same cycle; ready next cycle; rdata 0xDDCCBBAA.
- Store addr 0x8000_0000, wdata 0x12345678, wstrb F -> rqtype 1, size 010, nc 1, data 0x78563412_78563412; ST_ACK gives ready, rdata 0.
- Store wstrb 4'h4 -> size 000; wstrb 4'hC -> size 001.
- Hold l15_transducer_ack low for 5 cycles -> val and fields stable for all 5 cycles; val drops the cycle after ack.
- INT_RET arriving while in WAIT -> req_ack, one-cycle pico_int, no ready; a later LOAD_RET completes normally.
- Assert rst_n=0 while in WAIT -> outputs 0 immediately; a new load after reset completes normally.

Source files
------------

// File: rtl/l15_pkg.sv
// Shared L1.5 request/response encodings for the PicoRV32 bridge.
// Also holds width defaults and the byte-lane swap helper.
package l15_pkg;

   localparam int L15_PHY_ADDR_WIDTH = 40;
   localparam int L15_AMO_OP_WIDTH   = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT
   } state_t;

   localparam logic [4:0] RQ_LOAD  = 5'b00000;
   localparam logic [4:0] RQ_STORE = 5'b00001;
   localparam logic [4:0] RQ_AMO   = 5'b00110;

   localparam logic [3:0] RET_LOAD = 4'b0000;
   localparam logic [3:0] RET_ST   = 4'b0100;
   localparam logic [3:0] RET_INT  = 4'b0111;
   localparam logic [3:0] RET_AMO  = 4'b1001;

   localparam logic [2:0] SZ_BYTE = 3'b000;
   localparam logic [2:0] SZ_HALF = 3'b001;
   localparam logic [2:0] SZ_WORD = 3'b010;

   function automatic logic [31:0] byte_swap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   // Irregular strobe patterns fall back to a full word
   function automatic logic [2:0] store_size(input logic [3:0] s);
      case (s)
         4'hF:                   return SZ_WORD;
         4'h3, 4'hC:             return SZ_HALF;
         4'h1, 4'h2, 4'h4, 4'h8: return SZ_BYTE;
         default:                return SZ_WORD;
      endcase
   endfunction

endpackage

// File: rtl/pico_l15_bridge.sv
// PicoRV32 valid/ready memory port to OpenPiton L1.5 transducer.
// One request outstanding; returns load data and interrupt pulses.
module pico_l15_bridge
   import l15_pkg::*;
#(
   parameter int PHY_ADDR_WIDTH = L15_PHY_ADDR_WIDTH,
   parameter int AMO_OP_WIDTH   = L15_AMO_OP_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      pico_transducer_mem_valid,
   input  logic [31:0]               pico_transducer_mem_addr,
   input  logic [3:0]                pico_transducer_mem_wstrb,
   input  logic [31:0]               pico_transducer_mem_wdata,
   input  logic [AMO_OP_WIDTH-1:0]   pico_transducer_mem_amo_op,
   output logic                      transducer_pico_mem_ready,
   output logic [31:0]               transducer_pico_mem_rdata,
   output logic                      pico_int,
   output logic                      transducer_l15_val,
   output logic [4:0]                transducer_l15_rqtype,
   output logic [AMO_OP_WIDTH-1:0]   transducer_l15_amo_op,
   output logic [2:0]                transducer_l15_size,
   output logic [PHY_ADDR_WIDTH-1:0] transducer_l15_address,
   output logic [63:0]               transducer_l15_data,
   output logic                      transducer_l15_nc,
   input  logic                      l15_transducer_ack,
   input  logic                      l15_transducer_header_ack,
   output logic                      transducer_l15_threadid,
   output logic                      transducer_l15_prefetch,
   output logic                      transducer_l15_invalidate_cacheline,
   output logic                      transducer_l15_blockstore,
   output logic                      transducer_l15_blockinitstore,
   output logic [1:0]                transducer_l15_l1rplway,
   output logic [63:0]               transducer_l15_data_next_entry,
   output logic [32:0]               transducer_l15_csm_data,
   input  logic                      l15_transducer_val,
   input  logic [3:0]                l15_transducer_returntype,
   input  logic [63:0]               l15_transducer_data_0,
   input  logic [63:0]               l15_transducer_data_1,
   output logic                      transducer_l15_req_ack
);

   state_t state, state_nxt;

   logic        start;
   logic        done;
   logic        is_int;
   logic [4:0]  rq_d;
   logic [2:0]  sz_d;
   logic [3:0]  ret_d;
   logic [3:0]  exp_ret;
   logic [31:0] rword;
   logic [31:0] rdata_d;
   logic        unused_ok;

   // Valid is ignored during the ready cycle so a held request is not re-latched early
   assign start = (state == ST_IDLE) && pico_transducer_mem_valid
                  && !transducer_pico_mem_ready;
   assign done = (state == ST_WAIT) && l15_transducer_val
                 && (l15_transducer_returntype == exp_ret);
   assign is_int = l15_transducer_val
                   && (l15_transducer_returntype == RET_INT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (start) state_nxt = ST_REQ;
         ST_REQ:  if (l15_transducer_ack) state_nxt = ST_WAIT;
         ST_WAIT: if (done) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      transducer_l15_val     = (state == ST_REQ);
      transducer_l15_req_ack = l15_transducer_val;
   end

   always_comb begin
      rq_d  = RQ_LOAD;
      sz_d  = SZ_WORD;
      ret_d = RET_LOAD;
      if (pico_transducer_mem_amo_op != '0) begin
         rq_d  = RQ_AMO;
         ret_d = RET_AMO;
      end else if (pico_transducer_mem_wstrb != 4'h0) begin
         rq_d  = RQ_STORE;
         ret_d = RET_ST;
         sz_d  = store_size(pico_transducer_mem_wstrb);
      end
   end

   // L1.5 data is big-endian; address bit 2 picks the 32-bit half
   always_comb begin
      rword = transducer_l15_address[2] ? l15_transducer_data_0[31:0]
                                        : l15_transducer_data_0[63:32];
      rdata_d = (transducer_l15_rqtype == RQ_STORE) ? 32'h0
                                                    : byte_swap32(rword);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         transducer_l15_rqtype     <= '0;
         transducer_l15_size       <= '0;
         transducer_l15_address    <= '0;
         transducer_l15_data       <= '0;
         transducer_l15_nc         <= 1'b0;
         transducer_l15_amo_op     <= '0;
         exp_ret                   <= '0;
         transducer_pico_mem_ready <= 1'b0;
         transducer_pico_mem_rdata <= '0;
         pico_int                  <= 1'b0;
      end else begin
         if (start) begin
            transducer_l15_rqtype  <= rq_d;
            transducer_l15_size    <= sz_d;
            transducer_l15_address <= PHY_ADDR_WIDTH'(pico_transducer_mem_addr);
            transducer_l15_data    <= {2{byte_swap32(pico_transducer_mem_wdata)}};
            transducer_l15_nc      <= pico_transducer_mem_addr[31];
            transducer_l15_amo_op  <= pico_transducer_mem_amo_op;
            exp_ret                <= ret_d;
         end
         transducer_pico_mem_ready <= done;
         transducer_pico_mem_rdata <= done ? rdata_d : 32'h0;
         pico_int                  <= is_int;
      end
   end

   assign transducer_l15_threadid             = 1'b0;
   assign transducer_l15_prefetch             = 1'b0;
   assign transducer_l15_invalidate_cacheline = 1'b0;
   assign transducer_l15_blockstore           = 1'b0;
   assign transducer_l15_blockinitstore       = 1'b0;
   assign transducer_l15_l1rplway             = 2'b00;
   assign transducer_l15_data_next_entry      = 64'h0;
   assign transducer_l15_csm_data             = 33'h0;

   assign unused_ok = ^{l15_transducer_header_ack, l15_transducer_data_1};

endmodule

// File: tb/tb_pico_l15_bridge.sv
// Self-checking bench for pico_l15_bridge.
// Expected read data is queued when the response is driven.
module tb_pico_l15_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mv;
   logic [31:0] maddr;
   logic [3:0]  mstrb;
   logic [31:0] mwdata;
   logic [3:0]  mamo;
   logic        ready;
   logic [31:0] rdata;
   logic        pint;
   logic        lval;
   logic [4:0]  rqtype;
   logic [3:0]  lamo;
   logic [2:0]  lsize;
   logic [39:0] laddr;
   logic [63:0] ldata;
   logic        lnc;
   logic        ack;
   logic        hack;
   logic        tid, pf, inv, bs, bis;
   logic [1:0]  rplway;
   logic [63:0] dnext;
   logic [32:0] csm;
   logic        rval;
   logic [3:0]  rtype;
   logic [63:0] d0, d1;
   logic        req_ack;

   int nchk = 0;
   int nerr = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   pico_l15_bridge dut (
      .clk(clk),
      .rst_n(rst_n),
      .pico_transducer_mem_valid(mv),
      .pico_transducer_mem_addr(maddr),
      .pico_transducer_mem_wstrb(mstrb),
      .pico_transducer_mem_wdata(mwdata),
      .pico_transducer_mem_amo_op(mamo),
      .transducer_pico_mem_ready(ready),
      .transducer_pico_mem_rdata(rdata),
      .pico_int(pint),
      .transducer_l15_val(lval),
      .transducer_l15_rqtype(rqtype),
      .transducer_l15_amo_op(lamo),
      .transducer_l15_size(lsize),
      .transducer_l15_address(laddr),
      .transducer_l15_data(ldata),
      .transducer_l15_nc(lnc),
      .l15_transducer_ack(ack),
      .l15_transducer_header_ack(hack),
      .transducer_l15_threadid(tid),
      .transducer_l15_prefetch(pf),
      .transducer_l15_invalidate_cacheline(inv),
      .transducer_l15_blockstore(bs),
      .transducer_l15_blockinitstore(bis),
      .transducer_l15_l1rplway(rplway),
      .transducer_l15_data_next_entry(dnext),
      .transducer_l15_csm_data(csm),
      .l15_transducer_val(rval),
      .l15_transducer_returntype(rtype),
      .l15_transducer_data_0(d0),
      .l15_transducer_data_1(d1),
      .transducer_l15_req_ack(req_ack)
   );

   function automatic logic [31:0] swap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   // Scoreboard: every ready pulse pops one expected rdata
   always @(negedge clk) begin
      if (rst_n === 1'b1 && ready === 1'b1) begin
         nchk++;
         if (exp_q.size() == 0) begin
            nerr++;
            $display("FAIL sb_unexpected_ready: rdata %h, no request pending", rdata);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (rdata !== e) begin
               nerr++;
               $display("FAIL sb_rdata: got %h exp %h", rdata, e);
            end
         end
      end
   end

   task automatic send_req(input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] w, input logic [3:0] op);
      @(negedge clk);
      mv = 1'b1; maddr = a; mstrb = s; mwdata = w; mamo = op;
      @(negedge clk);
      mv = 1'b0;
   endtask

   task automatic ack_req();
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
   endtask

   task automatic respond(input logic [3:0] t, input logic [63:0] d,
                          input logic push, input logic [31:0] e);
      rval = 1'b1; rtype = t; d0 = d;
      if (push) exp_q.push_back(e);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      nchk++;
      if ({lval, ready, pint, req_ack, lnc} !== 5'b0) begin
         nerr++;
         $display("FAIL reset_ctrl: got %b exp 00000", {lval, ready, pint, req_ack, lnc});
      end
      nchk++;
      if ({rqtype, lsize, laddr, ldata, rdata, lamo} !== '0) begin
         nerr++;
         $display("FAIL reset_fields: got nonzero addr %h data %h", laddr, ldata);
      end
      nchk++;
      if ({tid, pf, inv, bs, bis, rplway, dnext, csm} !== '0) begin
         nerr++;
         $display("FAIL reset_ties: got nonzero tie-off");
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_load(input logic [31:0] a, input logic [63:0] d,
                            input logic [31:0] e);
      send_req(a, 4'h0, 32'hDEADBEEF, 4'h0);
      nchk++;
      if ({lval, rqtype, lsize, laddr, lnc} !== {1'b1, 5'd0, 3'b010, {8'h0, a}, 1'b0}) begin
         nerr++;
         $display("FAIL load_req: got val %b rq %h sz %b addr %h nc %b",
                  lval, rqtype, lsize, laddr, lnc);
      end
      ack_req();
      nchk++;
      if (lval !== 1'b0) begin
         nerr++;
         $display("FAIL load_val_drop: got %b exp 0", lval);
      end
      respond(4'b0000, d, 1'b1, e);
      nchk++;
      if ({req_ack, ready} !== 2'b10) begin
         nerr++;
         $display("FAIL load_req_ack: got %b exp 10", {req_ack, ready});
      end
      @(negedge clk);
      rval = 1'b0;
      nchk++;
      if (ready !== 1'b1) begin
         nerr++;
         $display("FAIL load_ready: got %b exp 1", ready);
      end
      @(negedge clk);
      nchk++;
      if (ready !== 1'b0) begin
         nerr++;
         $display("FAIL load_ready_pulse: got %b exp 0", ready);
      end
   endtask

   task automatic test_store();
      send_req(32'h8000_0000, 4'hF, 32'h1234_5678, 4'h0);
      nchk++;
      if ({rqtype, lsize, lnc, ldata} !== {5'd1, 3'b010, 1'b1, 64'h78563412_78563412}) begin
         nerr++;
         $display("FAIL store_req: got rq %h sz %b nc %b data %h", rqtype, lsize, lnc, ldata);
      end
      ack_req();
      respond(4'b0100, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 32'h0);
      @(negedge clk);
      rval = 1'b0;
      nchk++;
      if (ready !== 1'b1) begin
         nerr++;
         $display("FAIL store_ready: got %b exp 1", ready);
      end
      @(negedge clk);
   endtask

   task automatic test_store_sizes();
      logic [3:0] st[5] = '{4'h4, 4'hC, 4'h3, 4'h1, 4'h5};
      logic [2:0] sz[5] = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b010};
      for (int i = 0; i < 5; i++) begin
         send_req(32'h0000_0100, st[i], 32'hA5A5_0000 + i, 4'h0);
         nchk++;
         if (lsize !== sz[i] || rqtype !== 5'd1) begin
            nerr++;
            $display("FAIL store_size: strb %h got %b exp %b", st[i], lsize, sz[i]);
         end
         ack_req();
         respond(4'b0100, 64'h0, 1'b1, 32'h0);
         @(negedge clk);
         rval = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_amo();
      send_req(32'h0000_2004, 4'hF, 32'h0000_0001, 4'h3);
      nchk++;
      if ({rqtype, lsize, lamo} !== {5'b00110, 3'b010, 4'h3}) begin
         nerr++;
         $display("FAIL amo_req: got rq %h sz %b op %h", rqtype, lsize, lamo);
      end
      ack_req();
      // ST_ACK is not the expected return for an AMO and must be dropped
      respond(4'b0100, 64'h0, 1'b0, 32'h0);
      nchk++;
      if (req_ack !== 1'b1) begin
         nerr++;
         $display("FAIL amo_drop_ack: got %b exp 1", req_ack);
      end
      @(negedge clk);
      rval = 1'b0;
      nchk++;
      if (ready !== 1'b0) begin
         nerr++;
         $display("FAIL amo_drop_ready: got %b exp 0", ready);
      end
      respond(4'b1001, 64'h0102_0304_0506_0708, 1'b1, swap(32'h0506_0708));
      @(negedge clk);
      rval = 1'b0;
      nchk++;
      if (ready !== 1'b1) begin
         nerr++;
         $display("FAIL amo_ready: got %b exp 1", ready);
      end
      @(negedge clk);
   endtask

   task automatic test_ack_stall();
      send_req(32'h0000_3008, 4'h0, 32'h0, 4'h0);
      for (int i = 0; i < 5; i++) begin
         nchk++;
         if ({lval, rqtype, lsize, laddr} !== {1'b1, 5'd0, 3'b010, 40'h3008}) begin
            nerr++;
            $display("FAIL stall_hold%0d: got val %b addr %h", i, lval, laddr);
         end
         @(negedge clk);
      end
      ack_req();
      nchk++;
      if (lval !== 1'b0) begin
         nerr++;
         $display("FAIL stall_val_drop: got %b exp 0", lval);
      end
      respond(4'b0000, 64'hCAFE_F00D_0BAD_BEEF, 1'b1, swap(32'hCAFE_F00D));
      @(negedge clk);
      rval = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_interrupt();
      send_req(32'h0000_4004, 4'h0, 32'h0, 4'h0);
      ack_req();
      respond(4'b0111, 64'h0, 1'b0, 32'h0);
      nchk++;
      if (req_ack !== 1'b1) begin
         nerr++;
         $display("FAIL int_req_ack: got %b exp 1", req_ack);
      end
      @(negedge clk);
      rval = 1'b0;
      nchk++;
      if ({pint, ready} !== 2'b10) begin
         nerr++;
         $display("FAIL int_pulse: got int,ready %b exp 10", {pint, ready});
      end
      @(negedge clk);
      nchk++;
      if (pint !== 1'b0) begin
         nerr++;
         $display("FAIL int_one_cycle: got %b exp 0", pint);
      end
      respond(4'b0000, 64'h1111_2222_3333_4444, 1'b1, swap(32'h3333_4444));
      @(negedge clk);
      rval = 1'b0;
      nchk++;
      if (ready !== 1'b1) begin
         nerr++;
         $display("FAIL int_then_load: got %b exp 1", ready);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      send_req(32'h8000_0010, 4'hF, 32'hFFFF_FFFF, 4'h0);
      ack_req();
      rst_n = 1'b0;
      #1;
      nchk++;
      if ({lval, ready, pint, lnc, rqtype, laddr, ldata} !== '0) begin
         nerr++;
         $display("FAIL midreset_outputs: got val %b nc %b addr %h data %h",
                  lval, lnc, laddr, ldata);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_load(32'h0000_0008, 64'h0A0B_0C0D_0E0F_1011, swap(32'h0A0B_0C0D));
   endtask

   task automatic test_back_to_back();
      send_req(32'h0000_5000, 4'h0, 32'h0, 4'h0);
      ack_req();
      respond(4'b0000, 64'h5555_6666_7777_8888, 1'b1, swap(32'h5555_6666));
      @(negedge clk);
      rval = 1'b0;
      // Valid raised in the ready cycle must wait one cycle before sampling
      mv = 1'b1; maddr = 32'h0000_6000; mstrb = 4'h0; mamo = 4'h0;
      @(negedge clk);
      nchk++;
      if (lval !== 1'b0) begin
         nerr++;
         $display("FAIL b2b_no_sample: got %b exp 0", lval);
      end
      @(negedge clk);
      mv = 1'b0;
      nchk++;
      if (lval !== 1'b1 || laddr !== 40'h6000) begin
         nerr++;
         $display("FAIL b2b_issue: got val %b addr %h exp 1 6000", lval, laddr);
      end
      ack_req();
      respond(4'b0000, 64'h9999_AAAA_BBBB_CCCC, 1'b1, swap(32'h9999_AAAA));
      @(negedge clk);
      rval = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; mv = 1'b0; maddr = '0; mstrb = '0; mwdata = '0;
      mamo = '0; ack = 1'b0; hack = 1'b0; rval = 1'b0; rtype = '0;
      d0 = '0; d1 = '0;
      test_reset();
      test_load(32'h0000_1004, 64'h11223344_AABBCCDD, 32'hDDCCBBAA);
      test_load(32'h0000_2000, 64'h11223344_AABBCCDD, 32'h44332211);
      test_store();
      test_store_sizes();
      test_amo();
      test_ack_stall();
      test_interrupt();
      test_reset_mid();
      test_back_to_back();
      repeat (3) @(negedge clk);
      nchk++;
      if (exp_q.size() != 0) begin
         nerr++;
         $display("FAIL sb_leftover: got %0d pending exp 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
